// File: rtl/sim_ctrl_pkg.sv
// Shared encodings and defaults for the simulation run controller.
package sim_ctrl_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 6000;
    localparam int unsigned DEFAULT_HALT_STABLE    = 4;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] RESET_HOLD = 3'd1;
    localparam logic [2:0] RUN        = 3'd2;
    localparam logic [2:0] DUMP       = 3'd3;
    localparam logic [2:0] DONE       = 3'd4;

    typedef enum logic [2:0] {
        StIdle      = IDLE,
        StResetHold = RESET_HOLD,
        StRun       = RUN,
        StDump      = DUMP,
        StDone      = DONE
    } state_t;

endpackage

// File: rtl/pc_halt_detector.sv
// Flags a halt once the observed PC has been identical for HALT_STABLE consecutive cycles.
module pc_halt_detector
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned HALT_STABLE = DEFAULT_HALT_STABLE
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                halt_seen
);

    localparam int unsigned   SW         = $clog2(HALT_STABLE + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(HALT_STABLE - 1);

    logic [PC_WIDTH-1:0] prev_pc;
    logic                have_prev;
    logic [SW-1:0]       stable;
    logic [SW-1:0]       stable_next;

    // The first cycle after a clear has no previous PC, so it never counts as a repeat.
    always_comb begin
        stable_next = '0;
        if (have_prev && (pc == prev_pc)) begin
            stable_next = (stable == STABLE_MAX) ? stable : stable + SW'(1);
        end
    end

    assign halt_seen = ~clear & (stable_next == STABLE_MAX);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prev_pc   <= '0;
            have_prev <= 1'b0;
            stable    <= '0;
        end else begin
            prev_pc   <= pc;
            have_prev <= 1'b1;
            stable    <= stable_next;
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// Run-control sequencer: holds the core in reset, runs it until halt or timeout,
// then scans the register file, streams it out and checks one register.
module sim_run_controller
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned PC_WIDTH       = 32,
    parameter int unsigned RESET_CYCLES   = 2,
    parameter int unsigned HALT_STABLE    = DEFAULT_HALT_STABLE,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_WIDTH      = 32,
    localparam int unsigned ADDR_W        = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     check_reg,
    input  logic [DATA_WIDTH-1:0] check_value,
    output logic                  core_reset,
    input  logic [PC_WIDTH-1:0]   core_pc,
    output logic [ADDR_W-1:0]     reg_rd_addr,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  dump_valid,
    output logic [ADDR_W-1:0]     dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    localparam int unsigned       HOLD_W    = $clog2(RESET_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [ADDR_W-1:0]     check_reg_q;
    logic [DATA_WIDTH-1:0] check_value_q;
    logic                  halted;
    logic                  match;
    logic                  match_now;
    logic                  rd_busy;
    logic                  halt_seen;

    pc_halt_detector #(
        .PC_WIDTH    (PC_WIDTH),
        .HALT_STABLE (HALT_STABLE)
    ) u_halt (
        .clock     (clock),
        .reset     (reset),
        .clear     (state != StRun),
        .pc        (core_pc),
        .halt_seen (halt_seen)
    );

    // Compare against the dump entry currently on the outputs; needed on the DONE edge too.
    always_comb begin
        match_now = match;
        if (dump_valid && (dump_addr == check_reg_q)) begin
            match_now = (dump_data == check_value_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= StIdle;
            core_reset    <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            dump_valid    <= 1'b0;
            dump_addr     <= '0;
            dump_data     <= '0;
            cycle_count   <= '0;
            reg_rd_addr   <= '0;
            hold_cnt      <= '0;
            check_reg_q   <= '0;
            check_value_q <= '0;
            halted        <= 1'b0;
            match         <= 1'b0;
            rd_busy       <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state         <= StResetHold;
                        core_reset    <= 1'b1;
                        hold_cnt      <= '0;
                        check_reg_q   <= check_reg;
                        check_value_q <= check_value;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        timeout       <= 1'b0;
                        halted        <= 1'b0;
                        match         <= 1'b0;
                        cycle_count   <= '0;
                    end
                end
                StResetHold: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= StRun;
                        core_reset <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                StRun: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_WIDTH'(1);
                    end
                    // Halt takes priority over a timeout landing on the same cycle.
                    if (halt_seen) begin
                        halted      <= 1'b1;
                        state       <= StDump;
                        reg_rd_addr <= '0;
                        rd_busy     <= 1'b1;
                    end else if (cycle_count == TO_LAST) begin
                        timeout     <= 1'b1;
                        state       <= StDump;
                        reg_rd_addr <= '0;
                        rd_busy     <= 1'b1;
                    end
                end
                StDump: begin
                    match <= match_now;
                    if (rd_busy) begin
                        dump_valid <= 1'b1;
                        dump_addr  <= reg_rd_addr;
                        dump_data  <= reg_rd_data;
                        if (reg_rd_addr == ADDR_LAST) begin
                            rd_busy <= 1'b0;
                        end else begin
                            reg_rd_addr <= reg_rd_addr + ADDR_W'(1);
                        end
                    end else begin
                        dump_valid <= 1'b0;
                        state      <= StDone;
                        done       <= 1'b1;
                        pass       <= halted & ~timeout & match_now;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: a PC stub core and a small register file model.
module tb_sim_run_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  check_reg;
    logic [31:0] check_value;
    logic        core_reset;
    logic [31:0] core_pc;
    logic [4:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        dump_valid;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] cycle_count;

    logic [31:0] regs [0:31];
    logic [31:0] run_k;
    logic [31:0] hold_k;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    // Core stub: PC advances by 4 each run cycle until run cycle hold_k, then sticks there.
    always @(posedge clock) begin
        if (core_reset) run_k <= '0;
        else run_k <= run_k + 32'd1;
    end
    assign core_pc     = (run_k < hold_k) ? (run_k << 2) : (hold_k << 2);
    assign reg_rd_data = regs[reg_rd_addr];

    sim_run_controller #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .check_reg   (check_reg),
        .check_value (check_value),
        .core_reset  (core_reset),
        .core_pc     (core_pc),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .dump_valid  (dump_valid),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    // Called at a negedge; returns at the negedge of the first cycle after the start edge.
    task automatic do_start(input logic [4:0] creg, input logic [31:0] cval);
        check_reg   = creg;
        check_value = cval;
        start       = 1'b1;
        @(negedge clock);
        start       = 1'b0;
    endtask

    // Observes until done (bounded): core_reset-high cycles, dump entries seen and wrong ones.
    task automatic collect(output int rst_hi, output int dumps, output int bad,
                           output bit expired, output bit done_first);
        bit         low_seen = 1'b0;
        logic [4:0] idx;
        rst_hi     = 0;
        dumps      = 0;
        bad        = 0;
        expired    = 1'b1;
        done_first = done;
        for (int i = 0; i < 2000; i++) begin
            if (!low_seen && core_reset) rst_hi++;
            else low_seen = 1'b1;
            if (dump_valid) begin
                idx = 5'(dumps);
                if (dump_addr !== idx || dump_data !== regs[idx]) bad++;
                dumps++;
            end
            if (done) begin
                expired = 1'b0;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL reset.core_reset: got %0b want 1", core_reset); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset.done: got %0b want 0", done); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset.pass: got %0b want 0", pass); end
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset.timeout: got %0b want 0", timeout); end
        n_cmp++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL reset.dump_valid: got %0b want 0", dump_valid); end
        n_cmp++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset.cycle_count: got %0d want 0", cycle_count); end
        n_cmp++; if (reg_rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset.reg_rd_addr: got %0d want 0", reg_rd_addr); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_halt_pass();
        int rst_hi, dumps, bad;
        bit expired, done_first;
        hold_k = 32'd40;
        do_start(5'd9, 32'h10);
        collect(rst_hi, dumps, bad, expired, done_first);
        n_cmp++; if (expired !== 1'b0) begin n_fail++; $display("FAIL halt_pass.done_wait: got expired=%0b want 0", expired); end
        n_cmp++; if (rst_hi !== 2) begin n_fail++; $display("FAIL halt_pass.core_reset_cycles: got %0d want 2", rst_hi); end
        n_cmp++; if (dumps !== 32) begin n_fail++; $display("FAIL halt_pass.dump_count: got %0d want 32", dumps); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL halt_pass.dump_entries: got %0d bad want 0", bad); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL halt_pass.pass: got %0b want 1", pass); end
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL halt_pass.timeout: got %0b want 0", timeout); end
        n_cmp++; if (cycle_count !== 32'd44) begin n_fail++; $display("FAIL halt_pass.cycle_count: got %0d want 44", cycle_count); end
        n_cmp++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL halt_pass.core_reset_done: got %0b want 0", core_reset); end
        @(negedge clock);
        n_cmp++; if (done !== 1'b1 || dump_valid !== 1'b0) begin n_fail++; $display("FAIL halt_pass.done_sticky: got done=%0b dv=%0b want 1/0", done, dump_valid); end
    endtask

    // Starts from DONE, so this also covers the restart path.
    task automatic test_halt_mismatch();
        int rst_hi, dumps, bad;
        bit expired, done_first;
        hold_k = 32'd40;
        do_start(5'd9, 32'h15);
        collect(rst_hi, dumps, bad, expired, done_first);
        n_cmp++; if (done_first !== 1'b0) begin n_fail++; $display("FAIL restart.done_drop: got %0b want 0", done_first); end
        n_cmp++; if (rst_hi !== 2) begin n_fail++; $display("FAIL restart.core_reset_cycles: got %0d want 2", rst_hi); end
        n_cmp++; if (expired !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL mismatch.done: got done=%0b expired=%0b want 1/0", done, expired); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL mismatch.pass: got %0b want 0", pass); end
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL mismatch.timeout: got %0b want 0", timeout); end
        n_cmp++; if (dumps !== 32 || bad !== 0) begin n_fail++; $display("FAIL mismatch.dump: got %0d entries %0d bad want 32/0", dumps, bad); end
    endtask

    task automatic test_timeout();
        int rst_hi, dumps, bad;
        bit expired, done_first;
        hold_k = 32'd10000;
        do_start(5'd9, 32'h10);
        collect(rst_hi, dumps, bad, expired, done_first);
        n_cmp++; if (expired !== 1'b0) begin n_fail++; $display("FAIL timeout.done_wait: got expired=%0b want 0", expired); end
        n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout.flag: got %0b want 1", timeout); end
        n_cmp++; if (cycle_count !== 32'd100) begin n_fail++; $display("FAIL timeout.cycle_count: got %0d want 100", cycle_count); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL timeout.pass: got %0b want 0", pass); end
        n_cmp++; if (dumps !== 32 || bad !== 0) begin n_fail++; $display("FAIL timeout.dump: got %0d entries %0d bad want 32/0", dumps, bad); end
    endtask

    task automatic test_halt_vs_timeout();
        int rst_hi, dumps, bad;
        bit expired, done_first;
        // PC constant over run cycles 96..99: halt completes on the timeout cycle.
        hold_k = 32'd96;
        do_start(5'd9, 32'h10);
        collect(rst_hi, dumps, bad, expired, done_first);
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tie.timeout: got %0b want 0", timeout); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL tie.pass: got %0b want 1", pass); end
        n_cmp++; if (cycle_count !== 32'd100) begin n_fail++; $display("FAIL tie.cycle_count: got %0d want 100", cycle_count); end
        // Only three identical cycles before the timeout cycle ends the run.
        hold_k = 32'd97;
        do_start(5'd9, 32'h10);
        collect(rst_hi, dumps, bad, expired, done_first);
        n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL near_tie.timeout: got %0b want 1", timeout); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL near_tie.pass: got %0b want 0", pass); end
    endtask

    task automatic test_start_in_run();
        int rst_hi, dumps, bad;
        bit expired, done_first;
        hold_k = 32'd40;
        do_start(5'd9, 32'h10);
        repeat (12) @(negedge clock);
        check_value = 32'h15;
        start       = 1'b1;
        @(negedge clock);
        start       = 1'b0;
        collect(rst_hi, dumps, bad, expired, done_first);
        n_cmp++; if (rst_hi !== 0) begin n_fail++; $display("FAIL start_in_run.core_reset: got %0d high cycles want 0", rst_hi); end
        n_cmp++; if (cycle_count !== 32'd44) begin n_fail++; $display("FAIL start_in_run.cycle_count: got %0d want 44", cycle_count); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL start_in_run.pass: got %0b want 1", pass); end
    endtask

    task automatic test_reset_in_dump();
        int  rst_hi, dumps, bad;
        bit  expired, done_first;
        bit  found = 1'b0;
        hold_k = 32'd40;
        do_start(5'd9, 32'h10);
        for (int i = 0; i < 500; i++) begin
            if (dump_valid && dump_addr == 5'd10) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL reset_in_dump.reach_addr10: got %0b want 1", found); end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL reset_in_dump.core_reset: got %0b want 1", core_reset); end
        n_cmp++; if (done !== 1'b0 || dump_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_dump.outputs: got done=%0b dv=%0b want 0/0", done, dump_valid); end
        n_cmp++; if (cycle_count !== 32'd0 || reg_rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_in_dump.counters: got cc=%0d addr=%0d want 0/0", cycle_count, reg_rd_addr); end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (dump_valid !== 1'b0 || core_reset !== 1'b1) begin n_fail++; $display("FAIL reset_in_dump.idle: got dv=%0b cr=%0b want 0/1", dump_valid, core_reset); end
        do_start(5'd9, 32'h10);
        collect(rst_hi, dumps, bad, expired, done_first);
        n_cmp++; if (expired !== 1'b0 || pass !== 1'b1) begin n_fail++; $display("FAIL reset_in_dump.rerun: got pass=%0b expired=%0b want 1/0", pass, expired); end
        n_cmp++; if (dumps !== 32 || bad !== 0) begin n_fail++; $display("FAIL reset_in_dump.rerun_dump: got %0d entries %0d bad want 32/0", dumps, bad); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hC0DE_0000 + 32'(i) * 32'h111;
        regs[9]     = 32'h10;
        hold_k      = 32'd40;
        reset       = 1'b1;
        start       = 1'b0;
        check_reg   = '0;
        check_value = '0;
        @(negedge clock);
        test_reset();
        test_halt_pass();
        test_halt_mismatch();
        test_timeout();
        test_halt_vs_timeout();
        test_start_in_run();
        test_reset_in_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
